// File: rtl/phy_rst_seq.sv
// PHY reset/ready sequencer with a synchronised, debounced, sticky PHY interrupt flag and event counter.
// Drives the shared RGMII PHY reset pin and gates interrupt events on the READY state.
module phy_rst_seq #(
    parameter int unsigned RST_ASSERT_CYC = 125000,
    parameter int unsigned POST_WAIT_CYC  = 6250000,
    parameter int unsigned DEB_CYC        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_rst_req,
    input  logic        phy_int_n,
    input  logic        int_ack,
    output logic        phy_rst_n,
    output logic        phy_ready,
    output logic        int_pending,
    output logic [15:0] int_count,
    output logic [1:0]  seq_state
);

    localparam int unsigned MAX_CYC = (RST_ASSERT_CYC > POST_WAIT_CYC) ? RST_ASSERT_CYC : POST_WAIT_CYC;
    // Counters only ever hold terminal-1, so clog2 of the terminal value is enough.
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_ASSERT_CYC - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_WAIT_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_WAIT_READY = 2'd1,
        S_READY      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phy_rst_n_q, phy_rst_n_d;
    logic          phy_ready_q, phy_ready_d;

    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q, filt_prev_d;
    logic          pending_q, pending_d;
    logic [15:0]   count_q, count_d;
    logic          int_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_HOLD;
            cnt_q       <= '0;
            phy_rst_n_q <= 1'b0;
            phy_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_rst_n_q <= phy_rst_n_d;
            phy_ready_q <= phy_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_RESET_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_READY;
                    cnt_d   = '0;
                end
            end
            S_WAIT_READY: begin
                if (cnt_q == POST_LAST) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY: cnt_d = '0;
            default: begin
                state_d = S_RESET_HOLD;
                cnt_d   = '0;
            end
        endcase
        // Software request overrides any same-cycle expiry and restarts the hold.
        if (sw_rst_req) begin
            state_d = S_RESET_HOLD;
            cnt_d   = '0;
        end
        phy_rst_n_d = (state_d != S_RESET_HOLD);
        phy_ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            deb_q       <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            pending_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            sync_q      <= sync_d;
            deb_q       <= deb_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        sync_d      = {sync_q[0], phy_int_n};
        filt_d      = filt_q;
        deb_d       = '0;
        filt_prev_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (deb_q == DEB_LAST) filt_d = ~filt_q;
            else                   deb_d  = deb_q + 1'b1;
        end

        int_event = filt_prev_q & ~filt_q & (state_q == S_READY);

        pending_d = pending_q;
        count_d   = count_q;
        if (int_event) begin
            pending_d = 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end else if (int_ack) begin
            pending_d = 1'b0;
        end
        if (state_d == S_RESET_HOLD && (sw_rst_req || state_q != S_RESET_HOLD))
            pending_d = 1'b0;
    end

    assign phy_rst_n   = phy_rst_n_q;
    assign phy_ready   = phy_ready_q;
    assign int_pending = pending_q;
    assign int_count   = count_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_phy_rst_seq.sv
// Randomised bench for phy_rst_seq against an edge-counting reference model.
module tb_phy_rst_seq;

    localparam int RST  = 10;
    localparam int POST = 20;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        rst_n, sw_rst_req, phy_int_n, int_ack;
    logic        phy_rst_n, phy_ready, int_pending;
    logic [15:0] int_count;
    logic [1:0]  seq_state;

    phy_rst_seq #(.RST_ASSERT_CYC(RST), .POST_WAIT_CYC(POST), .DEB_CYC(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .phy_int_n(phy_int_n),
        .int_ack(int_ack), .phy_rst_n(phy_rst_n), .phy_ready(phy_ready),
        .int_pending(int_pending), .int_count(int_count), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: edges since release, edge of last software request,
    // the predicted interrupt event edge, and the software-visible flags.
    int          ek;
    int          last_req;
    int          ev_edge;
    logic        m_rstn, m_ready, m_pend;
    logic [1:0]  m_state;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ek);
        end
    endtask

    task automatic model_reset();
        ek = 0; last_req = 0; ev_edge = -1;
        m_rstn = 1'b0; m_ready = 1'b0; m_pend = 1'b0; m_state = 2'd0; m_cnt = 16'd0;
    endtask

    task automatic step();
        logic rb, ev;
        int   d;
        @(posedge clk);
        #1;
        ek++;
        rb = m_ready;
        if (sw_rst_req) last_req = ek;
        ev = (ek == ev_edge) && rb;
        if (ev) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_pend = 1'b1;
        end else if (int_ack) begin
            m_pend = 1'b0;
        end
        if (sw_rst_req) m_pend = 1'b0;
        d       = ek - last_req;
        m_rstn  = (d >= RST);
        m_ready = (d >= RST + POST);
        m_state = (d < RST) ? 2'd0 : (d < RST + POST) ? 2'd1 : 2'd2;
        chk("phy_rst_n", 32'(phy_rst_n), 32'(m_rstn));
        chk("phy_ready", 32'(phy_ready), 32'(m_ready));
        chk("seq_state", 32'(seq_state), 32'(m_state));
        chk("int_pending", 32'(int_pending), 32'(m_pend));
        chk("int_count", 32'(int_count), 32'(m_cnt));
    endtask

    // Low pulse of len edges starting at the next edge, then gap high edges;
    // int_ack is pulsed on relative edge ack_off (out of range = no ack).
    task automatic pulse(input int len, input int gap, input int ack_off);
        int s;
        s = ek + 1;
        ev_edge = (len >= DEB) ? s + DEB + 2 : -1;
        for (int i = 0; i < len + gap; i++) begin
            phy_int_n = (i < len) ? 1'b0 : 1'b1;
            int_ack   = (i == ack_off);
            step();
        end
        int_ack   = 1'b0;
        phy_int_n = 1'b1;
        ev_edge   = -1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !m_ready; i++) step();
        chk("wait_ready", 32'(phy_ready), 32'd1);
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sw_rst_req = 1'b0; phy_int_n = 1'b1; int_ack = 1'b0;
        model_reset();
        #23;
        chk("rst_phy_rst_n", 32'(phy_rst_n), 32'd0);
        chk("rst_phy_ready", 32'(phy_ready), 32'd0);
        chk("rst_int_count", 32'(int_count), 32'd0);
        chk("rst_seq_state", 32'(seq_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up sequence
        repeat (35) step();

        // Software reset at edge 40, second request at edge 45
        while (ek < 39) step();
        sw_pulse();
        repeat (4) step();
        sw_pulse();
        repeat (30) step();
        wait_ready();

        // Random software reset requests
        for (int i = 0; i < 200; i++) begin
            sw_rst_req = ($urandom_range(0, 39) == 0);
            step();
        end
        sw_rst_req = 1'b0;
        wait_ready();

        // Directed interrupt cases in READY
        pulse(6, 12, 99);
        pulse(6, 12, DEB + 3);
        pulse(3, 12, 99);
        pulse(DEB, 12, DEB + 4);
        pulse(6, 12, DEB + 2);
        pulse(DEB - 1, 12, 0);

        // Random interrupt pulses with random acknowledges
        for (int i = 0; i < 30; i++)
            pulse($urandom_range(1, 8), $urandom_range(9, 14), $urandom_range(0, 15));

        // Interrupt during WAIT_READY is discarded
        sw_pulse();
        repeat (11) step();
        pulse(7, 8, 99);
        wait_ready();

        // Saturation from a preloaded count
        @(negedge clk);
        dut.count_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        pulse(6, 12, 99);
        pulse(6, 12, DEB + 3);
        pulse(6, 12, 99);
        chk("sat_count", 32'(int_count), 32'h0000FFFF);

        // Asynchronous reset mid-WAIT_READY
        sw_pulse();
        repeat (15) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_phy_rst_n", 32'(phy_rst_n), 32'd0);
        chk("async_phy_ready", 32'(phy_ready), 32'd0);
        chk("async_int_pending", 32'(int_pending), 32'd0);
        chk("async_int_count", 32'(int_count), 32'd0);
        chk("async_seq_state", 32'(seq_state), 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (14) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
